// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: Op encodings, FSM states, default width.
// The control unit imports the Op encodings from here when decoding funct.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = mdu_pkg::MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wre;
    logic             lo_wre;
    logic [WIDTH-1:0] write_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_wre, lo_wre, write_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wre, lo_wre, write_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Signed ops run on magnitudes and are sign-corrected in a single FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);

    mdu_state_e         state_q;
    mdu_op_e            op_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;
    logic               prod_neg_q;
    logic               rem_neg_q;
    logic               bzero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               start_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               is_div;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        start_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        a_mag        = (start_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag        = (start_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // acc_q holds {partial product, remaining multiplier} for multiply and
    // {remainder, dividend bits / quotient bits} for divide.
    always_comb begin
        is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb_q};
        if (!is_div) begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Divide by zero leaves the remainder equal to |A|, so only LO needs forcing.
    always_comb begin
        prod_fix = prod_neg_q ? -acc_q : acc_q;
        quot_fix = bzero_q ? '1 : (prod_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= MDU_MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            prod_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            bzero_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.hi_wre) hi_q <= bus.write_data;
                    if (bus.lo_wre) lo_q <= bus.write_data;
                    if (bus.start) begin
                        op_q       <= mdu_op_e'(bus.op);
                        acc_q      <= {{WIDTH{1'b0}}, a_mag};
                        opb_q      <= b_mag;
                        prod_neg_q <= start_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rem_neg_q  <= start_signed && bus.a[WIDTH-1];
                        bzero_q    <= (bus.b == '0);
                        cnt_q      <= CntLoad;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: directed cases with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model of HI/LO/Busy/Done.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_cmp;
    int   n_bad;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Architectural result {HI, LO} of one operation, from plain arithmetic.
    function automatic logic [63:0] mdl(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        longint    sp;
        int        sa;
        int        sb;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                return up;
            end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    logic        busy_m;
    logic        done_m;
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [63:0] pend_m;
    int          left_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= 1'b0;
            done_m <= 1'b0;
            hi_m   <= '0;
            lo_m   <= '0;
            pend_m <= '0;
            left_m <= 0;
        end else begin
            done_m <= 1'b0;
            if (busy_m) begin
                if (left_m == 0) begin
                    busy_m <= 1'b0;
                    done_m <= 1'b1;
                    hi_m   <= pend_m[63:32];
                    lo_m   <= pend_m[31:0];
                end else begin
                    left_m <= left_m - 1;
                end
            end else begin
                if (bus.hi_wre) hi_m <= bus.write_data;
                if (bus.lo_wre) lo_m <= bus.write_data;
                if (bus.start) begin
                    busy_m <= 1'b1;
                    left_m <= W;
                    pend_m <= mdl(bus.op, bus.a, bus.b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, bus.busy}, {31'b0, busy_m});
            check("done", {31'b0, bus.done}, {31'b0, done_m});
            check("hi", bus.hi, hi_m);
            check("lo", bus.lo, lo_m);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where Done is seen (or after a bound).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_at, output int busy_cyc);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        busy_cyc  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start  = 1'b0;
            bus.hi_wre = 1'b0;
            bus.a      = $urandom;
            bus.b      = $urandom;
            if (i == inj_at) begin
                bus.start      = 1'b1;
                bus.op         = MDU_DIVU;
                bus.a          = 32'd99;
                bus.b          = 32'd4;
                bus.hi_wre     = 1'b1;
                bus.write_data = 32'hDEAD_BEEF;
            end
            if (bus.busy) busy_cyc++;
            if (bus.done) break;
        end
        check("done_seen", {31'b0, bus.done}, 32'd1);
    endtask

    int bc;
    int dones;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk_en = 1'b0;
        bus.start = 1'b0;
        bus.op = MDU_MULT;
        bus.a = '0;
        bus.b = '0;
        bus.hi_wre = 1'b0;
        bus.lo_wre = 1'b0;
        bus.write_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        do_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, -1, bc);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);
        @(negedge clk);
        do_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, -1, bc);
        check("multu_hi", bus.hi, 32'h0000_0002);
        check("multu_lo", bus.lo, 32'hFFFF_FFFA);
        check("multu_busy_cycles", 32'(bc), 32'd33);
        @(negedge clk);
        do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, -1, bc);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        @(negedge clk);
        do_op(MDU_DIVU, 32'd7, 32'd0, -1, bc);
        check("divu0_hi", bus.hi, 32'd7);
        check("divu0_lo", bus.lo, 32'hFFFF_FFFF);
        @(negedge clk);
        do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, bc);
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'h0);
        @(negedge clk);

        // Start/MTHI while busy ignored, then back-to-back Start in the Done cycle.
        do_op(MDU_MULTU, 32'd5, 32'd6, 9, bc);
        check("ign_hi", bus.hi, 32'd0);
        check("ign_lo", bus.lo, 32'd30);
        do_op(MDU_DIVU, 32'd100, 32'd7, -1, bc);
        check("b2b_hi", bus.hi, 32'd2);
        check("b2b_lo", bus.lo, 32'd14);
        check("b2b_busy_cycles", 32'(bc), 32'd33);
        @(negedge clk);

        // MTHI preload, then abort a DIV with reset.
        bus.hi_wre = 1'b1;
        bus.write_data = 32'h1234_5678;
        @(negedge clk);
        bus.hi_wre = 1'b0;
        check("mthi", bus.hi, 32'h1234_5678);
        bus.start = 1'b1;
        bus.op = MDU_DIV;
        bus.a = 32'd100;
        bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        #2 rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        bus.lo_wre = 1'b1;
        bus.write_data = 32'hCAFE_F00D;
        @(negedge clk);
        bus.lo_wre = 1'b0;
        check("mtlo_after_abort", bus.lo, 32'hCAFE_F00D);

        // Random traffic, including Start/MTHI/MTLO while busy and in the Done cycle.
        repeat (4000) begin
            @(negedge clk);
            bus.start      = ($urandom_range(0, 2) == 0);
            bus.op         = 2'($urandom_range(0, 3));
            bus.a          = pick();
            bus.b          = pick();
            bus.hi_wre     = ($urandom_range(0, 7) == 0);
            bus.lo_wre     = ($urandom_range(0, 7) == 0);
            bus.write_data = $urandom;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_wre = 1'b0;
        bus.lo_wre = 1'b0;
        repeat (40) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS CPU. It consumes the two register-file read ports (rs/rt) and holds results in the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles while asserting Busy so the control unit can stall. It also services MTHI/MTLO writes and drives HI/LO for MFHI/MFLO, which the writeback mux routes back into the register file.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- CLK  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low; clears all state
- Start  input  1  begin operation; sampled only in IDLE
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  WIDTH  rs operand (register-file ReadData1)
- B  input  WIDTH  rt operand (register-file ReadData2)
- HiWre  input  1  MTHI write enable
- LoWre  input  1  MTLO write enable
- WriteData  input  WIDTH  MTHI/MTLO data
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse when HI/LO receive a result
- HI  output  WIDTH  HI register (remainder / product upper half)
- LO  output  WIDTH  LO register (quotient / product lower half)

## Operation
- States: IDLE, RUN, FIX.
- IDLE + Start at an edge:
  - Latch Op.
  - Latch operands, converted to magnitudes when Op is signed.
  - Latch result signs:
    - Product sign and quotient sign = A[msb]^B[msb].
    - Remainder sign = A[msb].
  - Load count = WIDTH-1 and move to RUN.
- RUN, multiply: one radix-2 shift-add step per edge over a 2*WIDTH accumulator.
- RUN, divide: one restoring step per edge, shifting the remainder left and subtracting the divisor when it fits.
- RUN: count decrements each edge. The edge that performs the step with count==0 moves to FIX.
- FIX edge, multiply: negate the 2*WIDTH product if its sign is set. HI = upper half, LO = lower half.
- FIX edge, divide: negate the quotient and remainder per their signs. LO = quotient, HI = remainder.
- FIX edge, all ops: assert Done for the next cycle and return to IDLE.
- Divide by zero: no trap and the same latency. Result is HI = A as presented, LO = all ones.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- MTHI/MTLO in IDLE: HiWre/LoWre load WriteData into HI/LO at the edge.
- MTHI/MTLO while Busy: ignored.
- Start and HiWre/LoWre together in IDLE: both take effect. The later FIX overwrites HI/LO.
- Start while Busy: ignored, with no queuing. The stalled pipeline must hold Start and operands only until Busy falls.
- HI/LO keep their old value throughout RUN. Intermediate values never appear on HI/LO.

## Timing
- Reset values: Busy=0, Done=0, HI=0, LO=0, state IDLE, count=0.
- Reset asserted mid-operation aborts immediately. No Done is produced.
- Let edge 0 be the edge that accepts Start:
  - Busy=1 after edges 0 through WIDTH (RUN edges 1..WIDTH, FIX edge WIDTH+1).
  - Busy=0 and Done=1 after edge WIDTH+1; HI/LO valid from that same edge.
  - Latency is WIDTH+1 cycles (33 at the default).
- Done is high exactly one cycle. A new Start during that Done cycle is accepted, giving back-to-back operation with no idle bubble.
- Busy and Done are registered outputs with no combinational path from the inputs.
- A and B are sampled only at edge 0. They may change freely afterwards.

## Structure
- Shared package mdu_pkg holds:
  - Op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU.
  - The state enum IDLE/RUN/FIX.
  - The default WIDTH.
- The control unit imports the Op encodings from mdu_pkg when decoding funct.
- Single module. The iteration datapath and sign fix-up are small enough that no sub-module is warranted.
- The counter width is clog2(WIDTH).

## Test plan
- MULT with A=0xFFFFFFFE, B=3 -> after 33 cycles Done pulses; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA; Busy high for exactly 33 cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=0 -> HI=7, LO=0xFFFFFFFF.
- Start MULTU 5*6, then pulse Start with other operands and HiWre at cycle 10 -> both ignored; HI=0, LO=30. Next, Start DIVU 100/7 in the Done cycle -> HI=2, LO=14 with no idle gap.
- Preload HI=0x12345678 via HiWre in IDLE, start DIV, drop Reset at cycle 12 -> HI=LO=0, Busy=0, no Done pulse; a fresh MTLO afterwards works.
